// File: rtl/display_scan_driver.sv
// Scan controller for the 4-digit 7-segment display: slot prescaler, digit index,
// blanked active-low digit enables and a message select that only changes between frames.
module display_scan_driver #(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] sel_req,
  output logic       saida1Contador,
  output logic       saida2Contador,
  output logic [3:0] digito,
  output logic [1:0] sel_ativo,
  output logic       fim_quadro
);

  localparam int            PW       = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);
  localparam logic [PW-1:0] PRE_ZERO = PW'(0);

  logic [PW-1:0] pre_r, pre_nxt_s;
  logic [1:0]    idx_r, idx_nxt_s;
  logic [1:0]    sel_r, sel_nxt_s;
  logic          fim_r, fim_nxt_s;
  logic          tick_s;
  logic          blank_s;

  assign tick_s = (pre_r == PRE_LAST);

  // With no blanking the compare would be constant, so it is elaborated away.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign blank_s = 1'b0;
    end else begin : g_blank
      localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);
      assign blank_s = (pre_r < BLANK_END);
    end
  endgenerate

  // Next-state: advance the slot, wrap the digit, latch the select on a frame boundary.
  always_comb begin
    pre_nxt_s = pre_r;
    idx_nxt_s = idx_r;
    sel_nxt_s = sel_r;
    fim_nxt_s = 1'b0;
    if (enable) begin
      if (tick_s) begin
        pre_nxt_s = PRE_ZERO;
        idx_nxt_s = idx_r + 2'd1;
        if (idx_r == 2'd3) begin
          sel_nxt_s = sel_req;
          fim_nxt_s = 1'b1;
        end else begin
          sel_nxt_s = sel_r;
          fim_nxt_s = 1'b0;
        end
      end else begin
        pre_nxt_s = pre_r + PRE_ONE;
      end
    end else begin
      pre_nxt_s = pre_r;
      idx_nxt_s = idx_r;
      fim_nxt_s = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_r <= PRE_ZERO;
      idx_r <= 2'd0;
      sel_r <= 2'b00;
      fim_r <= 1'b0;
    end else begin
      pre_r <= pre_nxt_s;
      idx_r <= idx_nxt_s;
      sel_r <= sel_nxt_s;
      fim_r <= fim_nxt_s;
    end
  end

  // Digit enable decode; the blanking window at the slot start suppresses ghosting.
  always_comb begin
    digito = 4'b1111;
    if (!enable || blank_s) begin
      digito = 4'b1111;
    end else begin
      case (idx_r)
        2'd0:    digito = 4'b1110;
        2'd1:    digito = 4'b1101;
        2'd2:    digito = 4'b1011;
        2'd3:    digito = 4'b0111;
        default: digito = 4'b1111;
      endcase
    end
  end

  assign saida1Contador = idx_r[1];
  assign saida2Contador = idx_r[0];
  assign sel_ativo      = sel_r;
  assign fim_quadro     = fim_r;

endmodule

// File: tb/tb_display_scan_driver.sv
// Bench for display_scan_driver: two instances (PRESCALE=4/BLANK=1 and PRESCALE=2/BLANK=0)
// compared against an enabled-cycle-count model plus directed constants.
module tb_display_scan_driver;

  localparam int PA = 4;
  localparam int BA = 1;
  localparam int PB = 2;
  localparam int BB = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] sel_req = 2'b00;

  logic       a_c1, a_c0, a_fim, b_c1, b_c0, b_fim;
  logic [3:0] a_dig, b_dig;
  logic [1:0] a_sel, b_sel;

  int errors = 0;
  int checks = 0;

  // model: enabled-edge counts since reset, frame-latched selects and frame pulses
  int         na, nb;
  logic [1:0] sa, sb;
  logic       fa, fb;

  always #5 clk = ~clk;

  display_scan_driver #(.PRESCALE(PA), .BLANK_CYCLES(BA)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sel_req(sel_req),
    .saida1Contador(a_c1), .saida2Contador(a_c0), .digito(a_dig),
    .sel_ativo(a_sel), .fim_quadro(a_fim));

  display_scan_driver #(.PRESCALE(PB), .BLANK_CYCLES(BB)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sel_req(sel_req),
    .saida1Contador(b_c1), .saida2Contador(b_c0), .digito(b_dig),
    .sel_ativo(b_sel), .fim_quadro(b_fim));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      na <= 0; nb <= 0; sa <= 2'b00; sb <= 2'b00; fa <= 1'b0; fb <= 1'b0;
    end else begin
      fa <= 1'b0;
      fb <= 1'b0;
      if (enable) begin
        na <= na + 1;
        nb <= nb + 1;
        if ((na + 1) % (4 * PA) == 0) begin fa <= 1'b1; sa <= sel_req; end
        if ((nb + 1) % (4 * PB) == 0) begin fb <= 1'b1; sb <= sel_req; end
      end
    end
  end

  function automatic logic [3:0] exp_dig(int n, int p, int b, logic en);
    logic [3:0] one;
    int pre;
    int idx;
    one = 4'b0001;
    pre = n % p;
    idx = (n / p) % 4;
    if (!en || pre < b) return 4'b1111;
    return ~(one << idx);
  endfunction

  function automatic logic [1:0] exp_cnt(int n, int p);
    return 2'((n / p) % 4);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sel_req = 2'b00;
    enable = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    #3;
    checks++; if ({a_c1, a_c0} !== 2'b00) begin errors++; $display("FAIL reset a_cnt got=%b exp=00", {a_c1, a_c0}); end
    checks++; if (a_dig !== 4'b1111) begin errors++; $display("FAIL reset a_dig got=%b exp=1111", a_dig); end
    checks++; if (b_dig !== 4'b1111) begin errors++; $display("FAIL reset b_dig got=%b exp=1111", b_dig); end
    checks++; if (a_sel !== 2'b00 || b_sel !== 2'b00) begin errors++; $display("FAIL reset sel got=%b/%b exp=00/00", a_sel, b_sel); end
    checks++; if (a_fim !== 1'b0 || b_fim !== 1'b0) begin errors++; $display("FAIL reset fim got=%b/%b exp=0/0", a_fim, b_fim); end
    enable = 1'b1;
    #1;
    checks++; if (a_dig !== 4'b1111) begin errors++; $display("FAIL reset_en a_dig got=%b exp=1111", a_dig); end
    checks++; if (b_dig !== 4'b1110) begin errors++; $display("FAIL reset_en b_dig got=%b exp=1110", b_dig); end
  endtask

  // expects to be entered at the negedge of cycle 0 with enable=1, sel_req=0
  task automatic test_free_run(string tag);
    logic [3:0] bseq [8];
    bseq = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111};
    for (int k = 0; k <= 25; k++) begin
      checks++; if ({a_c1, a_c0} !== exp_cnt(na, PA)) begin errors++; $display("FAIL %s a_cnt cyc=%0d got=%b exp=%b", tag, k, {a_c1, a_c0}, exp_cnt(na, PA)); end
      checks++; if (a_dig !== exp_dig(na, PA, BA, enable)) begin errors++; $display("FAIL %s a_dig cyc=%0d got=%b exp=%b", tag, k, a_dig, exp_dig(na, PA, BA, enable)); end
      checks++; if (a_fim !== fa || a_sel !== sa) begin errors++; $display("FAIL %s a_fim/sel cyc=%0d got=%b/%b exp=%b/%b", tag, k, a_fim, a_sel, fa, sa); end
      checks++; if ({b_c1, b_c0} !== exp_cnt(nb, PB)) begin errors++; $display("FAIL %s b_cnt cyc=%0d got=%b exp=%b", tag, k, {b_c1, b_c0}, exp_cnt(nb, PB)); end
      checks++; if (b_dig !== bseq[k % 8]) begin errors++; $display("FAIL %s b_dig cyc=%0d got=%b exp=%b", tag, k, b_dig, bseq[k % 8]); end
      checks++; if (b_fim !== ((k % 8 == 0) && k != 0)) begin errors++; $display("FAIL %s b_fim cyc=%0d got=%b", tag, k, b_fim); end
      checks++; if (a_fim !== (k == 16)) begin errors++; $display("FAIL %s a_fim_const cyc=%0d got=%b", tag, k, a_fim); end
      if (k == 4) begin
        checks++; if ({a_c1, a_c0, a_dig} !== 6'b01_1111) begin errors++; $display("FAIL %s slot1_start got=%b exp=011111", tag, {a_c1, a_c0, a_dig}); end
      end
      if (k == 16) begin
        checks++; if ({a_c1, a_c0} !== 2'b00) begin errors++; $display("FAIL %s wrap_cnt got=%b exp=00", tag, {a_c1, a_c0}); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_frame_select();
    logic [1:0] exp;
    do_reset();
    for (int k = 0; k <= 33; k++) begin
      exp = (k < 16) ? 2'd0 : ((k < 32) ? 2'd2 : 2'd3);
      checks++; if (a_sel !== exp) begin errors++; $display("FAIL frame_sel a_sel cyc=%0d got=%0d exp=%0d", k, a_sel, exp); end
      checks++; if (b_sel !== sb || b_fim !== fb) begin errors++; $display("FAIL frame_sel b cyc=%0d got=%0d/%b exp=%0d/%b", k, b_sel, b_fim, sb, fb); end
      if (k == 4) sel_req = 2'd2;
      if (k == 20) sel_req = 2'd1;
      if (k == 31) sel_req = 2'd3;
      @(negedge clk);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    for (int k = 0; k <= 22; k++) begin
      checks++; if ({a_c1, a_c0} !== exp_cnt(na, PA)) begin errors++; $display("FAIL freeze a_cnt cyc=%0d got=%b exp=%b", k, {a_c1, a_c0}, exp_cnt(na, PA)); end
      checks++; if (a_dig !== exp_dig(na, PA, BA, enable)) begin errors++; $display("FAIL freeze a_dig cyc=%0d got=%b exp=%b", k, a_dig, exp_dig(na, PA, BA, enable)); end
      checks++; if (b_dig !== exp_dig(nb, PB, BB, enable) || b_fim !== fb) begin errors++; $display("FAIL freeze b cyc=%0d got=%b/%b", k, b_dig, b_fim); end
      checks++; if (a_fim !== (k == 19)) begin errors++; $display("FAIL freeze a_fim cyc=%0d got=%b exp=%b", k, a_fim, (k == 19)); end
      if (k >= 6 && k <= 8) begin
        checks++; if ({a_c1, a_c0, a_dig} !== 6'b01_1111) begin errors++; $display("FAIL freeze held cyc=%0d got=%b exp=011111", k, {a_c1, a_c0, a_dig}); end
      end
      if (k == 5) enable = 1'b0;
      if (k == 8) enable = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    int budget;
    do_reset();
    sel_req = 2'd3;
    budget = 0;
    while (!(na >= 4 * PA && exp_cnt(na, PA) == 2'd2 && (na % PA) >= BA) && budget < 60) begin
      @(negedge clk);
      budget++;
    end
    checks++; if (budget >= 60) begin errors++; $display("FAIL async wait_timeout got=%0d exp<60", budget); end
    checks++; if (a_dig !== 4'b1011 || a_sel !== 2'd3) begin errors++; $display("FAIL async pre_reset got=%b/%0d exp=1011/3", a_dig, a_sel); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({a_c1, a_c0} !== 2'b00 || a_dig !== 4'b1111) begin errors++; $display("FAIL async a_out got=%b/%b exp=00/1111", {a_c1, a_c0}, a_dig); end
    checks++; if (a_sel !== 2'b00 || a_fim !== 1'b0) begin errors++; $display("FAIL async a_sel/fim got=%0d/%b exp=0/0", a_sel, a_fim); end
    @(negedge clk);
    sel_req = 2'd0;
    rst_n = 1'b1;
    test_free_run("async_rerun");
  endtask

  task automatic test_random();
    logic [1:0] pa_sel, pb_sel;
    logic       pa_fim, pb_fim;
    do_reset();
    pa_sel = a_sel; pb_sel = b_sel; pa_fim = a_fim; pb_fim = b_fim;
    for (int k = 0; k < 10000; k++) begin
      checks++; if ({a_c1, a_c0} !== exp_cnt(na, PA) || a_dig !== exp_dig(na, PA, BA, enable)) begin errors++; $display("FAIL rand a_out cyc=%0d got=%b/%b exp=%b/%b", k, {a_c1, a_c0}, a_dig, exp_cnt(na, PA), exp_dig(na, PA, BA, enable)); end
      checks++; if (a_sel !== sa || a_fim !== fa) begin errors++; $display("FAIL rand a_frame cyc=%0d got=%0d/%b exp=%0d/%b", k, a_sel, a_fim, sa, fa); end
      checks++; if ({b_c1, b_c0} !== exp_cnt(nb, PB) || b_dig !== exp_dig(nb, PB, BB, enable)) begin errors++; $display("FAIL rand b_out cyc=%0d got=%b/%b exp=%b/%b", k, {b_c1, b_c0}, b_dig, exp_cnt(nb, PB), exp_dig(nb, PB, BB, enable)); end
      checks++; if (b_sel !== sb || b_fim !== fb) begin errors++; $display("FAIL rand b_frame cyc=%0d got=%0d/%b exp=%0d/%b", k, b_sel, b_fim, sb, fb); end
      checks++; if ($countones(~a_dig) > 1 || $countones(~b_dig) > 1) begin errors++; $display("FAIL rand onehot cyc=%0d got=%b/%b", k, a_dig, b_dig); end
      checks++; if (enable && b_dig === 4'b1111) begin errors++; $display("FAIL rand b_noblank cyc=%0d got=%b", k, b_dig); end
      checks++; if ((a_fim && pa_fim) || (b_fim && pb_fim)) begin errors++; $display("FAIL rand fim_double cyc=%0d got=%b%b/%b%b", k, pa_fim, a_fim, pb_fim, b_fim); end
      checks++; if ((a_sel !== pa_sel && a_fim !== 1'b1) || (b_sel !== pb_sel && b_fim !== 1'b1)) begin errors++; $display("FAIL rand sel_change cyc=%0d got=%0d/%0d", k, a_sel, b_sel); end
      pa_sel = a_sel; pb_sel = b_sel; pa_fim = a_fim; pb_fim = b_fim;
      enable = ($urandom_range(0, 7) != 0);
      sel_req = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    do_reset();
    test_free_run("free_run");
    test_frame_select();
    test_freeze();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
